// File: rtl/seyahat_pkg.sv
// Shared types and route table for the trip validator.
// The optional refuel feature is enabled with SEYAHAT_YAKIT_IKMAL_EN.
package seyahat_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] HATA_YOK      = 3'd0;
  localparam logic [2:0] HATA_YAKIT    = 3'd1;
  localparam logic [2:0] HATA_ROTA     = 3'd2;
  localparam logic [2:0] HATA_YETERSIZ = 3'd3;
  localparam logic [2:0] HATA_LIMIT    = 3'd4;

  localparam int ROTA_N = 4;

  localparam logic [5:0] ROTA_KOD [ROTA_N] = '{
    6'b111000, 6'b100011, 6'b100101, 6'b100110
  };

  localparam int ROTA_MALIYET [ROTA_N] = '{3, 2, 4, 5};

endpackage

// File: rtl/seyahat_denetleyici_rota_tablo.sv
// Combinational route lookup: route code -> {valid, fuel cost}.
// Part of the trip validator (optional refuel: SEYAHAT_YAKIT_IKMAL_EN).
module rota_tablo
  import seyahat_pkg::*;
#(
  parameter int ROUTE_W = 6,
  parameter int FUEL_W  = 4
) (
  input  logic [ROUTE_W-1:0] rota,
  output logic               gecerli,
  output logic [FUEL_W-1:0]  maliyet
);

  always_comb begin
    gecerli = 1'b0;
    maliyet = '0;
    for (int i = 0; i < ROTA_N; i++) begin
      if (rota == ROUTE_W'(ROTA_KOD[i])) begin
        gecerli = 1'b1;
        maliyet = FUEL_W'(ROTA_MALIYET[i]);
      end
    end
  end

endmodule

// File: rtl/seyahat_denetleyici.sv
// Multi-leg trip validator with fuel tracking and leg limit.
// Define SEYAHAT_YAKIT_IKMAL_EN to add the in-trip refuel inputs.
module seyahat_denetleyici
  import seyahat_pkg::*;
#(
  parameter int FUEL_W   = 4,
  parameter int ROUTE_W  = 6,
  parameter int MAX_LEGS = 4,
  parameter int MIN_FUEL = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [FUEL_W-1:0]                yakit,
  input  logic                             leg_valid,
  output logic                             leg_ready,
  input  logic [ROUTE_W-1:0]               rota,
  input  logic                             leg_last,
`ifdef SEYAHAT_YAKIT_IKMAL_EN
  input  logic                             ikmal_valid,
  input  logic [FUEL_W-1:0]                ikmal_miktar,
`endif
  output logic                             busy,
  output logic                             done,
  output logic                             seyahat_dogru,
  output logic [FUEL_W-1:0]                kalan_yakit,
  output logic [$clog2(MAX_LEGS+1)-1:0]    leg_count,
  output logic [2:0]                       hata_kodu
);

  localparam int CW = $clog2(MAX_LEGS + 1);
  localparam logic [FUEL_W-1:0] MIN_F = FUEL_W'(MIN_FUEL);
  localparam logic [CW-1:0]     MAX_C = CW'(MAX_LEGS);

  state_e state_q, state_d;
  logic [FUEL_W-1:0] yakit_q, yakit_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        hata_q, hata_d;
  logic              dogru_q, dogru_d;
  logic              done_q, done_d;

  logic              run, accept, start_ok, low;
  logic              rv, short;
  logic [FUEL_W-1:0] cost, fuel_eff;
  logic [CW-1:0]     cnt_inc;

  rota_tablo #(.ROUTE_W(ROUTE_W), .FUEL_W(FUEL_W)) u_tablo (
    .rota    (rota),
    .gecerli (rv),
    .maliyet (cost)
  );

  assign run      = (state_q == S_RUN);
  assign accept   = leg_valid && run;
  assign start_ok = start && !run;
  assign low      = (yakit < MIN_F);
  assign cnt_inc  = cnt_q + CW'(1);

  // Refuel lands before the cost check of a same-cycle leg.
`ifdef SEYAHAT_YAKIT_IKMAL_EN
  logic [FUEL_W:0] sum;
  assign sum = {1'b0, yakit_q} + {1'b0, ikmal_miktar};
  always_comb begin
    fuel_eff = yakit_q;
    if (ikmal_valid)
      fuel_eff = sum[FUEL_W] ? '1 : sum[FUEL_W-1:0];
  end
`else
  assign fuel_eff = yakit_q;
`endif

  assign short = (cost > fuel_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_ok) begin
      state_d = low ? S_DONE : S_RUN;
    end else if (accept) begin
      if (!rv || short || leg_last || cnt_inc == MAX_C)
        state_d = S_DONE;
    end
  end

  always_comb begin
    yakit_d = yakit_q;
    cnt_d   = cnt_q;
    hata_d  = hata_q;
    dogru_d = dogru_q;
    done_d  = 1'b0;
    if (start_ok) begin
      yakit_d = yakit;
      cnt_d   = '0;
      hata_d  = low ? HATA_YAKIT : HATA_YOK;
      dogru_d = 1'b0;
      done_d  = low;
    end else if (run) begin
      yakit_d = fuel_eff;
      if (accept) begin
        if (!rv) begin
          hata_d = HATA_ROTA;
          done_d = 1'b1;
        end else if (short) begin
          hata_d = HATA_YETERSIZ;
          done_d = 1'b1;
        end else begin
          yakit_d = fuel_eff - cost;
          cnt_d   = cnt_inc;
          if (leg_last) begin
            dogru_d = 1'b1;
            hata_d  = HATA_YOK;
            done_d  = 1'b1;
          end else if (cnt_inc == MAX_C) begin
            hata_d = HATA_LIMIT;
            done_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yakit_q <= '0;
      cnt_q   <= '0;
      hata_q  <= '0;
      dogru_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      yakit_q <= yakit_d;
      cnt_q   <= cnt_d;
      hata_q  <= hata_d;
      dogru_q <= dogru_d;
      done_q  <= done_d;
    end
  end

  assign leg_ready     = run;
  assign busy          = run;
  assign done          = done_q;
  assign seyahat_dogru = dogru_q;
  assign kalan_yakit   = yakit_q;
  assign leg_count     = cnt_q;
  assign hata_kodu     = hata_q;

endmodule
